tthbif_uart_rf: RTL and testbench

TTHBIF_UART_RF -- requirements
Module: tthbif_uart_rf

---
 rtl/tthbif_pkg.sv | 25 ++
 rtl/tthbif_timeout_cnt.sv | 29 ++
 rtl/tthbif_uart_rf.sv | 139 +++++++++++++
 tb/tb_tthbif_uart_rf.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tthbif_pkg.sv
// Shared constants and FSM state type for the tthbif UART register file.
package tthbif_pkg;

   localparam logic [3:0] ADDR_RX_FLOP = 4'd0;
   localparam logic [3:0] ADDR_RX_COMB = 4'd1;
   localparam logic [3:0] ADDR_TX_FLOP = 4'd2;
   localparam logic [3:0] ADDR_TX_COMB = 4'd3;
   localparam logic [3:0] ADDR_ID      = 4'd4;
   localparam logic [3:0] ADDR_SCRATCH = 4'd5;
   localparam logic [3:0] ADDR_STATUS  = 4'd6;

   localparam logic [7:0] ID_VALUE  = 8'hA5;
   localparam logic [7:0] ACK_VALUE = 8'h06;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WR_DATA,
      ST_RESP
   } state_t;

   function automatic logic is_read_cmd(input logic [7:0] cmd);
      return cmd[7];
   endfunction

endpackage

// File: rtl/tthbif_timeout_cnt.sv
// Write-data timeout counter: clears on a write command, counts while enabled,
// flags expiry once LIMIT cycles have been spent waiting.
module tthbif_timeout_cnt #(
   parameter int unsigned LIMIT = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count;

   assign expired = (count == CW'(LIMIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/tthbif_uart_rf.sv
// UART-driven register file for tthbif tap selects (read/write command protocol).
// Define TTHBIF_RF_WR_ACK_EN to have every completed write answered with an ACK byte.
module tthbif_uart_rf
   import tthbif_pkg::*;
#(
   parameter int NUM_FLOP_TAP   = 4,
   parameter int NUM_COMB_TAP   = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            en_i,
   input  logic                            rx_data_valid_i,
   input  logic [7:0]                      rx_data_i,
   input  logic                            tx_data_ready_i,
   output logic                            tx_data_valid_o,
   output logic [7:0]                      tx_data_o,
   output logic [$clog2(NUM_FLOP_TAP)-1:0] rx_flop_tap_sel_o,
   output logic [$clog2(NUM_FLOP_TAP)-1:0] tx_flop_tap_sel_o,
   output logic [$clog2(NUM_COMB_TAP)-1:0] rx_comb_tap_sel_o,
   output logic [$clog2(NUM_COMB_TAP)-1:0] tx_comb_tap_sel_o
);

   localparam int FW = $clog2(NUM_FLOP_TAP);
   localparam int CW = $clog2(NUM_COMB_TAP);

   state_t        state;
   logic [3:0]    wr_addr;
   logic [7:0]    scratch;
   logic          drop_flag;
   logic [FW-1:0] rx_flop_sel;
   logic [FW-1:0] tx_flop_sel;
   logic [CW-1:0] rx_comb_sel;
   logic [CW-1:0] tx_comb_sel;
   logic [7:0]    rd_data;
   logic          timeout_clear;
   logic          timeout_enable;
   logic          timeout_expired;

   assign rx_flop_tap_sel_o = rx_flop_sel;
   assign tx_flop_tap_sel_o = tx_flop_sel;
   assign rx_comb_tap_sel_o = rx_comb_sel;
   assign tx_comb_tap_sel_o = tx_comb_sel;

   assign timeout_clear  = en_i && (state == ST_IDLE) && rx_data_valid_i && !is_read_cmd(rx_data_i);
   assign timeout_enable = en_i && (state == ST_WR_DATA);

   tthbif_timeout_cnt #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk_i),
      .rst_n  (rst_ni),
      .clear  (timeout_clear),
      .enable (timeout_enable),
      .expired(timeout_expired)
   );

   // Read data is decoded straight from the command byte so the response can be
   // registered in the command cycle itself.
   always_comb begin
      rd_data = 8'h00;
      case (rx_data_i[3:0])
         ADDR_RX_FLOP: rd_data = 8'(rx_flop_sel);
         ADDR_RX_COMB: rd_data = 8'(rx_comb_sel);
         ADDR_TX_FLOP: rd_data = 8'(tx_flop_sel);
         ADDR_TX_COMB: rd_data = 8'(tx_comb_sel);
         ADDR_ID:      rd_data = ID_VALUE;
         ADDR_SCRATCH: rd_data = scratch;
         ADDR_STATUS:  rd_data = {7'b0, drop_flag};
         default:      rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state           <= ST_IDLE;
         tx_data_valid_o <= 1'b0;
         tx_data_o       <= 8'h00;
         wr_addr         <= 4'h0;
         scratch         <= 8'h00;
         drop_flag       <= 1'b0;
         rx_flop_sel     <= '1;
         tx_flop_sel     <= '1;
         rx_comb_sel     <= '1;
         tx_comb_sel     <= '1;
      end else if (!en_i) begin
         state           <= ST_IDLE;
         tx_data_valid_o <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (rx_data_valid_i) begin
                  if (is_read_cmd(rx_data_i)) begin
                     tx_data_o       <= rd_data;
                     tx_data_valid_o <= 1'b1;
                     state           <= ST_RESP;
                     if (rx_data_i[3:0] == ADDR_STATUS) drop_flag <= 1'b0;
                  end else begin
                     wr_addr <= rx_data_i[3:0];
                     state   <= ST_WR_DATA;
                  end
               end
            end
            ST_WR_DATA: begin
               if (rx_data_valid_i) begin
                  case (wr_addr)
                     ADDR_RX_FLOP: rx_flop_sel <= rx_data_i[FW-1:0];
                     ADDR_RX_COMB: rx_comb_sel <= rx_data_i[CW-1:0];
                     ADDR_TX_FLOP: tx_flop_sel <= rx_data_i[FW-1:0];
                     ADDR_TX_COMB: tx_comb_sel <= rx_data_i[CW-1:0];
                     ADDR_SCRATCH: scratch     <= rx_data_i;
                     default: ;
                  endcase
`ifdef TTHBIF_RF_WR_ACK_EN
                  tx_data_o       <= ACK_VALUE;
                  tx_data_valid_o <= 1'b1;
                  state           <= ST_RESP;
`else
                  state <= ST_IDLE;
`endif
               end else if (timeout_expired) begin
                  state <= ST_IDLE;
               end
            end
            ST_RESP: begin
               // The response slot has no room for another command, so any byte
               // seen here is lost and recorded.
               if (rx_data_valid_i) drop_flag <= 1'b1;
               if (tx_data_ready_i) begin
                  tx_data_valid_o <= 1'b0;
                  state           <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tthbif_uart_rf.sv
// Scoreboard bench for tthbif_uart_rf: stimulus pushes expected tx bytes, a monitor
// pops them on every tx handshake. Honours TTHBIF_RF_WR_ACK_EN when defined.
module tb_tthbif_uart_rf;

   logic       clk_i;
   logic       rst_ni;
   logic       en_i;
   logic       rx_data_valid_i;
   logic [7:0] rx_data_i;
   logic       tx_data_ready_i;
   logic       tx_data_valid_o;
   logic [7:0] tx_data_o;
   logic [1:0] rx_flop_tap_sel_o;
   logic [1:0] tx_flop_tap_sel_o;
   logic [1:0] rx_comb_tap_sel_o;
   logic [1:0] tx_comb_tap_sel_o;

   logic [7:0] exp_q[$];
   int         vec_count  = 0;
   int         miss_count = 0;

   tthbif_uart_rf #(
      .NUM_FLOP_TAP  (4),
      .NUM_COMB_TAP  (4),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .en_i             (en_i),
      .rx_data_valid_i  (rx_data_valid_i),
      .rx_data_i        (rx_data_i),
      .tx_data_ready_i  (tx_data_ready_i),
      .tx_data_valid_o  (tx_data_valid_o),
      .tx_data_o        (tx_data_o),
      .rx_flop_tap_sel_o(rx_flop_tap_sel_o),
      .tx_flop_tap_sel_o(tx_flop_tap_sel_o),
      .rx_comb_tap_sel_o(rx_comb_tap_sel_o),
      .tx_comb_tap_sel_o(tx_comb_tap_sel_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      vec_count++;
      if (actual !== expected) begin
         miss_count++;
         $display("[TB] FAIL %s: got %02h, expected %02h", name, actual, expected);
      end
   endtask

   task automatic sendByte(input logic [7:0] b);
      @(posedge clk_i); #1;
      rx_data_valid_i = 1'b1;
      rx_data_i       = b;
      @(posedge clk_i); #1;
      rx_data_valid_i = 1'b0;
      rx_data_i       = 8'h00;
   endtask

   task automatic applyStimulus(input logic [7:0] b, input int idle);
      sendByte(b);
      repeat (idle) @(posedge clk_i);
      #1;
   endtask

   task automatic doWrite(input logic [7:0] cmd, input logic [7:0] data);
      applyStimulus(cmd, 0);
`ifdef TTHBIF_RF_WR_ACK_EN
      exp_q.push_back(8'h06);
`endif
      applyStimulus(data, 3);
   endtask

   task automatic doRead(input logic [7:0] cmd, input logic [7:0] expected);
      exp_q.push_back(expected);
      applyStimulus(cmd, 3);
   endtask

   // Monitor: every accepted tx byte must match the oldest expectation.
   always @(negedge clk_i) begin
      if (rst_ni && tx_data_valid_o && tx_data_ready_i) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_tx_byte", tx_data_o, 8'hxx);
         end else begin
            checkOutput("tx_byte", tx_data_o, exp_q.pop_front());
         end
      end
   end

   initial begin
      rst_ni          = 1'b0;
      en_i            = 1'b1;
      rx_data_valid_i = 1'b0;
      rx_data_i       = 8'h00;
      tx_data_ready_i = 1'b1;

      repeat (3) @(posedge clk_i);
      #1;
      checkOutput("reset_rx_flop", 8'(rx_flop_tap_sel_o), 8'h03);
      checkOutput("reset_rx_comb", 8'(rx_comb_tap_sel_o), 8'h03);
      checkOutput("reset_tx_flop", 8'(tx_flop_tap_sel_o), 8'h03);
      checkOutput("reset_tx_comb", 8'(tx_comb_tap_sel_o), 8'h03);
      checkOutput("reset_valid", 8'(tx_data_valid_o), 8'h00);
      checkOutput("reset_data", tx_data_o, 8'h00);
      rst_ni = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;

      // Tap write lands the cycle after the data byte
      applyStimulus(8'h02, 0);
`ifdef TTHBIF_RF_WR_ACK_EN
      exp_q.push_back(8'h06);
`endif
      @(posedge clk_i); #1;
      rx_data_valid_i = 1'b1;
      rx_data_i       = 8'h01;
      checkOutput("tx_flop_before_write", 8'(tx_flop_tap_sel_o), 8'h03);
      @(posedge clk_i); #1;
      rx_data_valid_i = 1'b0;
      rx_data_i       = 8'h00;
      checkOutput("tx_flop_after_write", 8'(tx_flop_tap_sel_o), 8'h01);
      checkOutput("rx_flop_untouched", 8'(rx_flop_tap_sel_o), 8'h03);
      checkOutput("tx_comb_untouched", 8'(tx_comb_tap_sel_o), 8'h03);
      repeat (3) @(posedge clk_i);
      #1;

      // Read latency of one cycle
      exp_q.push_back(8'h01);
      @(posedge clk_i); #1;
      rx_data_valid_i = 1'b1;
      rx_data_i       = 8'h82;
      checkOutput("valid_during_cmd", 8'(tx_data_valid_o), 8'h00);
      @(posedge clk_i); #1;
      rx_data_valid_i = 1'b0;
      rx_data_i       = 8'h00;
      checkOutput("read_latency_valid", 8'(tx_data_valid_o), 8'h01);
      repeat (3) @(posedge clk_i);
      #1;
      checkOutput("valid_after_read", 8'(tx_data_valid_o), 8'h00);

      // Back-pressure: response held stable until ready
      tx_data_ready_i = 1'b0;
      exp_q.push_back(8'hA5);
      sendByte(8'h84);
      for (int i = 0; i < 5; i++) begin
         checkOutput("hold_valid", 8'(tx_data_valid_o), 8'h01);
         checkOutput("hold_data", tx_data_o, 8'hA5);
         @(posedge clk_i); #1;
      end
      tx_data_ready_i = 1'b1;
      checkOutput("valid_in_ready_cycle", 8'(tx_data_valid_o), 8'h01);
      @(posedge clk_i); #1;
      checkOutput("valid_after_accept", 8'(tx_data_valid_o), 8'h00);
      repeat (2) @(posedge clk_i);
      #1;

      // Timeout: next byte one cycle past the window is a fresh command
      sendByte(8'h05);
      repeat (15) @(posedge clk_i);
      exp_q.push_back(8'h00);
      sendByte(8'h85);
      repeat (3) @(posedge clk_i);
      #1;

      // Data byte in the last cycle of the window is still written
      sendByte(8'h05);
      repeat (14) @(posedge clk_i);
`ifdef TTHBIF_RF_WR_ACK_EN
      exp_q.push_back(8'h06);
`endif
      sendByte(8'h3C);
      repeat (3) @(posedge clk_i);
      #1;
      doRead(8'h85, 8'h3C);

      // Byte during RESP is dropped and flagged; status clears on read
      tx_data_ready_i = 1'b0;
      exp_q.push_back(8'h03);
      sendByte(8'h80);
      sendByte(8'h01);
      tx_data_ready_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      checkOutput("dropped_byte_no_write", 8'(rx_flop_tap_sel_o), 8'h03);
      doRead(8'h86, 8'h01);
      doRead(8'h86, 8'h00);

      // Byte in the tx-accept cycle is dropped too
      tx_data_ready_i = 1'b0;
      exp_q.push_back(8'h3C);
      sendByte(8'h85);
      @(posedge clk_i); #1;
      tx_data_ready_i = 1'b1;
      rx_data_valid_i = 1'b1;
      rx_data_i       = 8'h05;
      @(posedge clk_i); #1;
      rx_data_valid_i = 1'b0;
      rx_data_i       = 8'h00;
      repeat (3) @(posedge clk_i);
      #1;
      doRead(8'h86, 8'h01);

      // Unmapped / read-only addresses, ignored command bits, comb taps
      doRead(8'h8F, 8'h00);
      doWrite(8'h0F, 8'h55);
      doRead(8'h85, 8'h3C);
      doWrite(8'h04, 8'h00);
      doRead(8'h84, 8'hA5);
      doWrite(8'h75, 8'h99);
      doRead(8'hF5, 8'h99);
      doWrite(8'h01, 8'hFE);
      checkOutput("rx_comb_low_bits", 8'(rx_comb_tap_sel_o), 8'h02);
      doRead(8'h81, 8'h02);

      // Enable low aborts RESP and ignores rx bytes
      tx_data_ready_i = 1'b0;
      sendByte(8'h84);
      checkOutput("valid_before_disable", 8'(tx_data_valid_o), 8'h01);
      en_i = 1'b0;
      @(posedge clk_i); #1;
      checkOutput("valid_after_disable", 8'(tx_data_valid_o), 8'h00);
      sendByte(8'h83);
      repeat (3) @(posedge clk_i);
      #1;
      en_i            = 1'b1;
      tx_data_ready_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      checkOutput("valid_after_reenable", 8'(tx_data_valid_o), 8'h00);
      doRead(8'h86, 8'h00);
      doRead(8'h85, 8'h99);

      // Reset in the middle of a write discards it
      sendByte(8'h02);
      rst_ni = 1'b0;
      #3;
      checkOutput("midreset_tx_flop", 8'(tx_flop_tap_sel_o), 8'h03);
      checkOutput("midreset_valid", 8'(tx_data_valid_o), 8'h00);
      rst_ni = 1'b1;
      exp_q.push_back(8'h03);
      sendByte(8'h82);
      repeat (3) @(posedge clk_i);
      #1;
      checkOutput("post_reset_tx_flop", 8'(tx_flop_tap_sel_o), 8'h03);

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk_i);
      #1;
      checkOutput("pending_responses", 8'(exp_q.size()), 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule
